// File: rtl/gost89_mac_verify.sv
// gost89_mac_verify: GOST 28147-89 MAC (imitovstavka) chain with received-tag compare.
// One Feistel round per clock, 16 rounds per 64-bit block, no final swap.
module gost89_mac_verify #(
    parameter int TAG_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                load_data,
    input  logic                last,
    input  logic [511:0]        sbox,
    input  logic [255:0]        key,
    input  logic [63:0]         in,
    input  logic [TAG_BITS-1:0] tag_in,
    output logic                busy,
    output logic                done,
    output logic                mac_ok,
    output logic [TAG_BITS-1:0] mac_out
);
    typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

    state_t                state, state_nx;
    logic [63:0]           s, s_nx;
    logic [31:0]           n1, n2, rk, sum, sub, f;
    logic [3:0]            cnt;
    logic                  last_q, accept, clear, final_round;
    logic [TAG_BITS-1:0]   tag_q, tag_nx;
    logic [31:0]           kw [8];
    logic [3:0]            tbl [8][16];

    for (genvar k = 0; k < 8; k++) begin : g_tbl
        assign kw[k] = key[255-32*k -: 32];
        for (genvar v = 0; v < 16; v++) begin : g_ent
            assign tbl[k][v] = sbox[511-64*k-4*v -: 4];
        end
        assign sub[4*k +: 4] = tbl[k][sum[4*k +: 4]];
    end

    assign rk          = kw[cnt[2:0]];
    assign sum         = n1 + rk;
    assign f           = {sub[20:0], sub[31:21]};
    assign s_nx        = {n2 ^ f, n1};
    assign tag_nx      = s_nx[63 -: TAG_BITS];
    assign busy        = state == ROUND;
    assign done        = state == FINISH;
    assign accept      = !busy && load_data;
    assign clear       = !busy && start;
    assign final_round = busy && cnt == 4'd15;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        state_nx = accept ? ROUND :
                   !busy  ? IDLE  :
                   !final_round ? ROUND :
                   last_q ? FINISH : IDLE;
    end

    // The compare result is registered on the last round so it is valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            s       <= '0;
            n1      <= '0;
            n2      <= '0;
            cnt     <= '0;
            last_q  <= 1'b0;
            tag_q   <= '0;
            mac_ok  <= 1'b0;
            mac_out <= '0;
        end else if (busy) begin
            n1  <= n2 ^ f;
            n2  <= n1;
            cnt <= cnt + 4'd1;
            if (final_round) begin
                s <= s_nx;
                if (last_q) begin
                    mac_out <= tag_nx;
                    mac_ok  <= tag_nx == tag_q;
                end
            end
        end else begin
            if (clear)
                s <= '0;
            if (clear || accept) begin
                mac_ok  <= 1'b0;
                mac_out <= '0;
            end
            if (accept) begin
                {n1, n2} <= (clear ? 64'd0 : s) ^ in;
                last_q   <= last;
                tag_q    <= tag_in;
                cnt      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_gost89_mac_verify.sv
// tb_gost89_mac_verify: directed-vector bench for gost89_mac_verify (TAG_BITS 32 and 16).
module tb_gost89_mac_verify;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         load_data = 1'b0;
    logic         last = 1'b0;
    logic [511:0] sbox = '0;
    logic [255:0] key = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888;
    logic [63:0]  in = '0;
    logic [31:0]  tag_in = '0;
    logic [15:0]  tag_in16 = '0;
    logic         busy, done, mac_ok, busy16, done16, mac_ok16;
    logic [31:0]  mac_out;
    logic [15:0]  mac_out16;
    int           total = 0;
    int           passed = 0;

    always #5 clk = ~clk;

    gost89_mac_verify #(.TAG_BITS(32)) dut (
        .clk(clk), .reset(reset), .start(start), .load_data(load_data), .last(last),
        .sbox(sbox), .key(key), .in(in), .tag_in(tag_in),
        .busy(busy), .done(done), .mac_ok(mac_ok), .mac_out(mac_out)
    );

    gost89_mac_verify #(.TAG_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .load_data(load_data), .last(last),
        .sbox(sbox), .key(key), .in(in), .tag_in(tag_in16),
        .busy(busy16), .done(done16), .mac_ok(mac_ok16), .mac_out(mac_out16)
    );

    typedef struct {
        int          nblk;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [31:0] tag;
        logic [31:0] exp_mac;
        logic        exp_ok;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: sixteen rounds with key order K0..K7,K0..K7 and no final swap.
    function automatic logic [63:0] enc(input logic [63:0] x, input logic [511:0] sbx,
                                        input logic [255:0] k);
        logic [31:0] a, b, t, u, r;
        logic [3:0]  v;
        a = x[63:32];
        b = x[31:0];
        for (int i = 0; i < 16; i++) begin
            u = a + k[255-32*(i%8) -: 32];
            for (int j = 0; j < 8; j++) begin
                v = u[4*j +: 4];
                r[4*j +: 4] = sbx[511-64*j-4*v -: 4];
            end
            t = b ^ {r[20:0], r[31:21]};
            b = a;
            a = t;
        end
        return {a, b};
    endfunction

    // Called on a falling edge; returns on the falling edge of cycle t+17.
    task automatic send_block(input logic [63:0] blk, input logic lst, input logic [31:0] tg,
                              input logic st, input int inj_ld, input int inj_st, input string nm);
        int bc;
        start     = st;
        load_data = 1'b1;
        in        = blk;
        last      = lst;
        tag_in    = tg;
        tag_in16  = tg[31:16];
        @(negedge clk);
        bc = 0;
        for (int j = 0; j < 16; j++) begin
            load_data = (j == inj_ld);
            start     = (j == inj_st);
            if (j == inj_ld) in = ~blk;
            if (busy) bc++;
            @(negedge clk);
        end
        load_data = 1'b0;
        start     = 1'b0;
        chk({nm, "_busy_cycles"}, 64'(bc), 64'd16);
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'(lst));
        chk({nm, "_done16"}, 64'(done16), 64'(lst));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t        vecs[5];
    logic [63:0] blks[8];
    logic [63:0] s_exp;
    logic [31:0] tg;
    int          nb, dcnt, fb;

    initial begin
        vecs[0] = '{1, 64'h0, 64'h0123456789ABCDEF, 32'h01234567, 32'h01234567, 1'b1};
        vecs[1] = '{2, 64'hFFFF0000_12345678, 64'h0F0F0000_00000000, 32'hF0F00001, 32'hF0F00000, 1'b0};
        vecs[2] = '{2, 64'hFFFF0000_12345678, 64'h0F0F0000_00000000, 32'hF0F00000, 32'hF0F00000, 1'b1};
        vecs[3] = '{1, 64'h0, 64'hFFFFFFFF_00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{1, 64'h0, 64'h0000000000000000, 32'h80000000, 32'h00000000, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mac_ok", 64'(mac_ok), 64'd0);
        chk("rst_mac_out", 64'(mac_out), 64'd0);

        // Zero S-box: every round is a pure swap, so 16 rounds return the input.
        foreach (vecs[i]) begin
            do_start();
            if (vecs[i].nblk == 2) send_block(vecs[i].b0, 1'b0, 32'h0, 1'b0, -1, -1, "v_b0");
            send_block(vecs[i].b1, 1'b1, vecs[i].tag, 1'b0, -1, -1, "v_last");
            chk("v_mac_out", 64'(mac_out), 64'(vecs[i].exp_mac));
            chk("v_mac_ok", 64'(mac_ok), 64'(vecs[i].exp_ok));
            chk("v_mac_out16", 64'(mac_out16), 64'(vecs[i].exp_mac[31:16]));
            chk("v_mac_ok16", 64'(mac_ok16), 64'(vecs[i].tag[31:16] == vecs[i].exp_mac[31:16]));
        end

        for (int i = 0; i < 16; i++) sbox[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;

        foreach (blks[i]) blks[i] = {$urandom, $urandom};
        for (int t = 0; t < 4; t++) begin
            nb = (t == 3) ? 8 : 2 * t + 1;
            s_exp = '0;
            for (int b = 0; b < nb; b++) s_exp = enc(s_exp ^ blks[b], sbox, key);
            for (int pass = 0; pass < 2; pass++) begin
                fb = $urandom_range(16, 31);
                tg = (pass == 0) ? s_exp[63:32] : s_exp[63:32] ^ (32'd1 << fb);
                do_start();
                for (int b = 0; b < nb - 1; b++) send_block(blks[b], 1'b0, 32'h0, 1'b0, -1, -1, "r_mid");
                send_block(blks[nb-1], 1'b1, tg, 1'b0, -1, -1, "r_last");
                chk("r_mac_out", 64'(mac_out), 64'(s_exp[63:32]));
                chk("r_mac_ok", 64'(mac_ok), 64'(pass == 0));
                chk("r_mac_out16", 64'(mac_out16), 64'(s_exp[63:48]));
                chk("r_mac_ok16", 64'(mac_ok16), 64'(pass == 0));
            end
        end

        // load_data and start pulsed while busy must be ignored.
        do_start();
        s_exp = enc(blks[0], sbox, key);
        send_block(blks[0], 1'b1, s_exp[63:32], 1'b0, 15, 7, "inj");
        chk("inj_mac_out", 64'(mac_out), 64'(s_exp[63:32]));
        chk("inj_mac_ok", 64'(mac_ok), 64'd1);

        // No start after a last block: chaining continues from S.
        s_exp = enc(s_exp ^ blks[1], sbox, key);
        send_block(blks[1], 1'b1, s_exp[63:32], 1'b0, -1, -1, "chain");
        chk("chain_mac_out", 64'(mac_out), 64'(s_exp[63:32]));
        chk("chain_mac_ok", 64'(mac_ok), 64'd1);

        // start together with load_data: block absorbed into a zero state.
        s_exp = enc(blks[2], sbox, key);
        send_block(blks[2], 1'b1, s_exp[63:32], 1'b1, -1, -1, "stld");
        chk("stld_mac_out", 64'(mac_out), 64'(s_exp[63:32]));
        chk("stld_mac_ok", 64'(mac_ok), 64'd1);

        // Reset while idle clears the held result.
        @(negedge clk);
        chk("hold_mac_ok", 64'(mac_ok), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("idle_rst_mac_ok", 64'(mac_ok), 64'd0);
        chk("idle_rst_mac_out", 64'(mac_out), 64'd0);

        // Reset at round 7 discards the block in progress.
        do_start();
        in = blks[3];
        load_data = 1'b1;
        last = 1'b1;
        tag_in = 32'h0;
        @(negedge clk);
        load_data = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_mac_ok", 64'(mac_ok), 64'd0);
        dcnt = 0;
        repeat (20) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("mid_rst_quiet", 64'(dcnt), 64'd0);
        s_exp = enc(blks[4], sbox, key);
        send_block(blks[4], 1'b1, s_exp[63:32], 1'b0, -1, -1, "post_rst");
        chk("post_rst_mac_out", 64'(mac_out), 64'(s_exp[63:32]));
        chk("post_rst_mac_ok", 64'(mac_ok), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gost89_mac_verify.md
Name: gost89_mac_verify

Overview:
- Receiver-side GOST 28147-89 imitovstavka (MAC) checker.
- Absorbs a message as a sequence of 64-bit blocks and computes the 16-round MAC chain, S = E16(S ^ P). After the last block it compares the 32-bit tag against a received tag and reports pass/fail.
- Sits downstream of gost89_cfb_decrypt on the receive path.
- Contains its own iterative round engine: one Feistel round per clock.

Parameters:
- TAG_BITS, 32, compared tag width; tag is S[63:64-TAG_BITS]; legal values 1..32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin new message: S <= 0; ignored while busy
- load_data  in  1  one-cycle strobe: absorb `in`; ignored while busy
- last  in  1  sampled with load_data: this block ends the message
- sbox  in  512  S-box table; entry v of box k = sbox[511-64k-4v -: 4]; box 0 acts on nibble [3:0]
- key  in  256  K0 = key[255:224] … K7 = key[31:0]
- in  in  64  message block
- tag_in  in  TAG_BITS  received tag, sampled with load_data when last=1
- busy  out  1  rounds in progress
- done  out  1  one-cycle pulse when the final compare completes
- mac_ok  out  1  compare result, valid from done until the next start or load_data
- mac_out  out  TAG_BITS  computed tag, same validity as mac_ok

Behaviour:
- Reset values: busy=0, done=0, mac_ok=0, mac_out=0, S=0, round counter=0, state IDLE. Reset overrides everything, including mid-round operation; the message in progress is discarded.
- States:
  - IDLE: waiting for start or a block.
  - ROUND: executing rounds.
  - FINISH: performing the tag compare.
- start in IDLE: S <= 0, mac_ok <= 0, mac_out <= 0. If start and load_data are high in the same cycle, clear is applied first and the block is absorbed into the zero state.
- load_data in IDLE:
  - Latch x = S ^ in, with n1 = x[63:32] and n2 = x[31:0].
  - Latch last and tag_in; set busy=1; counter=0; go to ROUND.
- ROUND, each cycle i = 0..15:
  - f = rol11(SBOX(n1 + K[i mod 8])), addition mod 2^32.
  - n1 <= n2 ^ f; n2 <= n1.
- Key order is K0..K7, K0..K7. There is no final swap; S <= {n1, n2} after round 15.
- Timing:
  - Block latency: load_data at cycle t, busy=1 during cycles t+1..t+16, S updated at the end of cycle t+16.
  - Not last: return to IDLE with busy=0 at t+17.
  - Last: go to FINISH. At t+17, mac_out <= S[63:64-TAG_BITS], mac_ok <= (that == tag_in), done=1 for one cycle, busy=0, return to IDLE. S retains its value.
- Next message after a last block requires start. A load_data without start continues chaining from S (permitted, not an error).
- load_data or start asserted while busy: ignored, with no latching and no side effects.
- Throughput: one block per 17 cycles; back-to-back load_data is accepted on the first cycle busy=0.
- mac_ok and mac_out hold until the next start or load_data, either of which clears both to 0.

Test Plan:
- Zero S-box, any key. Cases with sbox=0 (f=0, 16 swaps = identity):
  - start, one block 0x0123456789ABCDEF, last=1, tag_in=0x01234567 -> done at load+17, mac_out=0x01234567, mac_ok=1.
  - Two blocks 0xFFFF0000_12345678 then 0x0F0F0000_00000000 (last) -> mac_out=0xF0F00000; with tag_in=0xF0F00001 -> mac_ok=0.
- Latency/busy: verify busy high for exactly 16 cycles per block; load_data pulsed mid-busy with a different `in` -> result unchanged; start mid-busy -> ignored.
- Reset mid-operation: reset at round 7 -> next cycle busy=0, done=0, mac_ok=0, S=0; following single-block message matches a fresh run.
- Random key/S-box and 1–8 random blocks, TAG_BITS=32 and 16 -> mac_out matches a C reference model of the MAC chain; correct tag gives mac_ok=1, any single flipped tag bit gives mac_ok=0.
- Simultaneous start+load_data after a completed message -> block absorbed into S=0; result equals a fresh single-block MAC.
